// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the fifo_buf synchronous FIFO.
// Optional sticky error flags are built in with FIFO_ERR_EN.
package fifo_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int AF_LVL_DEF = 28;
    localparam int AE_LVL_DEF = 4;

    // Entry count for a given address width, usable in constant expressions.
    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    // Pointer carries one extra wrap bit beyond the storage address.
    typedef logic [ADDR_W_DEF:0] fifo_ptr_t;

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage for fifo_buf: one write port, one registered read port.
// No reset on the array or the read register.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
    end

endmodule

// File: rtl/fifo_buf.sv
// Synchronous FIFO with storage, occupancy count and almost-full/empty thresholds.
// Define FIFO_ERR_EN to add sticky ovf/udf outputs and the formal properties.
module fifo_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int AF_LVL = AF_LVL_DEF,
    parameter int AE_LVL = AE_LVL_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              emp,
    output logic              full,
    output logic              almost_full,
    output logic              almost_empty,
`ifdef FIFO_ERR_EN
    output logic [ADDR_W:0]   count,
    output logic              ovf,
    output logic              udf
`else
    output logic [ADDR_W:0]   count
`endif
);

    localparam int DEPTH = fifo_depth(ADDR_W);
    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              primed;
    logic [DATA_W-1:0] mem_q;

    assign count        = wr_ptr - rd_ptr;
    assign emp          = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign almost_full  = (count >= CNT_W'(AF_LVL));
    assign almost_empty = (count <= CNT_W'(AE_LVL));

    assign wr_acc = wr & ~full;
    assign rd_acc = rd & ~emp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_valid <= 1'b0;
            primed   <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                primed <= 1'b1;
            end
        end
    end

    // The storage read register is unreset; mask it to zero until the first
    // read after reset so rd_data still comes up (and resets) to zero.
    assign rd_data = primed ? mem_q : '0;

    fifo_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr[ADDR_W-1:0]),
        .wdata (wr_data),
        .re    (rd_acc),
        .raddr (rd_ptr[ADDR_W-1:0]),
        .rdata (mem_q)
    );

`ifdef FIFO_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            if (wr && full)
                ovf <= 1'b1;
            if (rd && emp)
                udf <= 1'b1;
        end
    end

    a_not_full_emp: assert property (@(posedge clk) disable iff (rst) !(full && emp));
    a_count_max:    assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));
    a_wr_hold:      assert property (@(posedge clk) disable iff (rst)
                                     (!wr_acc) |=> (wr_ptr == $past(wr_ptr)));
    a_rd_hold:      assert property (@(posedge clk) disable iff (rst)
                                     (!rd_acc) |=> (rd_ptr == $past(rd_ptr)));
`endif

endmodule

// File: tb/tb_fifo_buf.sv
// Directed scoreboard bench for fifo_buf (default 8x32 configuration).
module tb_fifo_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0;
    logic [7:0] wr_data = '0;
    logic       rd = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, emp, full, almost_full, almost_empty;
    logic [5:0] count;
`ifdef FIFO_ERR_EN
    logic       ovf, udf;
`endif

    fifo_buf dut (
        .clk          (clk),
        .rst          (rst),
        .wr           (wr),
        .wr_data      (wr_data),
        .rd           (rd),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .emp          (emp),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`ifdef FIFO_ERR_EN
        .count        (count),
        .ovf          (ovf),
        .udf          (udf)
`else
        .count        (count)
`endif
    );

    always #5 clk = ~clk;

    int         pass_cnt = 0;
    int         tot_cnt  = 0;
    int         fail_cnt = 0;
    logic [7:0] q[$];
    logic [7:0] last_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tot_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags();
        int n = q.size();
        chk("count", 32'(count), 32'(n));
        chk("emp", 32'(emp), 32'(n == 0));
        chk("full", 32'(full), 32'(n == 32));
        chk("almost_full", 32'(almost_full), 32'(n >= 28));
        chk("almost_empty", 32'(almost_empty), 32'(n <= 4));
    endtask

    // One clock: drive requests, predict acceptance from the queue, check after the edge.
    task automatic cycle(input logic w, input logic [7:0] d, input logic r);
        int         n = q.size();
        logic       exp_v;
        logic [7:0] exp_d;
        wr = w; wr_data = d; rd = r;
        exp_v = r && (n > 0);
        exp_d = last_data;
        if (exp_v) exp_d = q.pop_front();
        if (w && n < 32) q.push_back(d);
        @(posedge clk); #1;
        chk("rd_valid", 32'(rd_valid), 32'(exp_v));
        chk("rd_data", 32'(rd_data), 32'(exp_d));
        last_data = exp_d;
        chk_flags();
        wr = 1'b0; rd = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset / idle
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        chk_flags();
        cycle(1'b0, 8'h00, 1'b0);

        // fill 0x00..0x1F, then an overflowing write
        for (int i = 0; i < 32; i++) cycle(1'b1, 8'(i), 1'b0);
        chk("full_at_32", 32'(full), 32'd1);
        cycle(1'b1, 8'hEE, 1'b0);
        chk("count_after_ovf", 32'(count), 32'd32);
`ifdef FIFO_ERR_EN
        chk("ovf", 32'(ovf), 32'd1);
`endif

        // drain in order, then an underflowing read
        for (int i = 0; i < 32; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("emp_after_drain", 32'(emp), 32'd1);
        chk("last_word", 32'(rd_data), 32'h1F);
        cycle(1'b0, 8'h00, 1'b1);
        chk("udf_rd_valid", 32'(rd_valid), 32'd0);
`ifdef FIFO_ERR_EN
        chk("udf", 32'(udf), 32'd1);
`endif

        // steady state at count=10 with simultaneous rd/wr
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1);
        chk("count_hold_10", 32'(count), 32'd10);

        // simultaneous at full: write rejected
        for (int i = 0; i < 22; i++) cycle(1'b1, 8'(8'h80 + i), 1'b0);
        chk("full_before_rw", 32'(full), 32'd1);
        cycle(1'b1, 8'hF0, 1'b1);
        chk("count_full_rw", 32'(count), 32'd31);

        // simultaneous at empty: read rejected, no bypass
        for (int i = 0; i < 31; i++) cycle(1'b0, 8'h00, 1'b1);
        chk("emp_before_rw", 32'(emp), 32'd1);
        cycle(1'b1, 8'h5A, 1'b1);
        chk("count_emp_rw", 32'(count), 32'd1);
        cycle(1'b0, 8'h00, 1'b1);
        chk("emp_rw_word", 32'(rd_data), 32'h5A);

        // interleaved pairs: pointers wrap several times
        for (int i = 0; i < 100; i++) begin
            cycle(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            cycle(1'b0, 8'h00, 1'b1);
        end

        // asynchronous reset mid-burst at count=17
        for (int i = 0; i < 17; i++) cycle(1'b1, 8'(8'hB0 + i), 1'b0);
        chk("count_17", 32'(count), 32'd17);
        #3 rst = 1'b1;
        #1;
        chk("async_count", 32'(count), 32'd0);
        chk("async_emp", 32'(emp), 32'd1);
        chk("async_rd_data", 32'(rd_data), 32'd0);
        #1 rst = 1'b0;
        q.delete();
        last_data = '0;
        @(posedge clk); #1;
        chk_flags();
        cycle(1'b1, 8'hC3, 1'b0);
        cycle(1'b0, 8'h00, 1'b1);
        chk("post_rst_word", 32'(rd_data), 32'hC3);
        cycle(1'b0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/fifo_buf.md
Name: fifo_buf

Overview:
Parametrised synchronous FIFO with integrated storage. It succeeds the pointer-only FIFO controller and adds a data path, a fill-level count, programmable almost-full/almost-empty thresholds, and defined simultaneous read/write behaviour. It sits between a producer and a consumer in the same clock domain. Depth is a power of two set by ADDR_W.

Parameters:
DATA_W, 8, data word width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries (default 32)
AF_LVL, 28, almost_full asserts when count >= AF_LVL; legal range 1..DEPTH
AE_LVL, 4, almost_empty asserts when count <= AE_LVL; legal range 0..DEPTH-1

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
wr  in  1  write request
wr_data  in  DATA_W  write data, sampled with an accepted write
rd  in  1  read request
rd_data  out  DATA_W  read data, registered
rd_valid  out  1  high for one cycle when rd_data holds a newly read word
emp  out  1  FIFO empty
full  out  1  FIFO full
almost_full  out  1  count >= AF_LVL
almost_empty  out  1  count <= AE_LVL
count  out  ADDR_W+1  current occupancy, range 0..DEPTH
ovf  out  1  sticky overflow error (FIFO_ERR_EN only)
udf  out  1  sticky underflow error (FIFO_ERR_EN only)

Behaviour:
- Clock and reset: clk is the clock. rst is asynchronous, active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, emp=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, ovf=0, udf=0. Storage array is not reset.
- Pointers: wr_ptr and rd_ptr are ADDR_W+1 bits and wrap modulo 2**(ADDR_W+1). The low ADDR_W bits address storage.
- Occupancy: count = wr_ptr - rd_ptr, computed modulo 2**(ADDR_W+1).
- Flags (combinational from registered pointers):
  - emp = (count==0)
  - full = (count==DEPTH)
  - emp and full are never both high.
- Write acceptance: wr_acc = wr & !full. On wr_acc, mem[wr_ptr[ADDR_W-1:0]] <= wr_data and wr_ptr increments.
- Read acceptance: rd_acc = rd & !emp. On rd_acc, rd_data <= mem[rd_ptr[ADDR_W-1:0]] and rd_ptr increments.
- Read latency: one cycle. rd_valid is high the cycle after rd_acc, otherwise 0. rd_data holds its last value when no read is accepted.
- Simultaneous rd and wr:
  - Not empty and not full: both accepted, count unchanged.
  - Empty: write accepted, read rejected. The new word is not bypassed to rd_data.
  - Full: read accepted, write rejected. No write-through.
- Rejected requests leave all state unchanged, except the error flags below.
- Flags and count reflect the new state in the cycle after an accepted operation.
- Reset mid-operation: contents are discarded and all outputs return to their reset values immediately (asynchronous). Operation resumes on the first clock edge after rst deasserts.

Optional Feature:
Macro FIFO_ERR_EN.
- Defined:
  - ovf sets on wr & full; udf sets on rd & emp.
  - Both flags are sticky and clear only on rst.
  - Formal properties are included: never full & emp; count <= DEPTH; no pointer movement on a rejected request.
- Undefined: ovf and udf ports are absent and no error logic is synthesised. Request gating is identical in both builds.

Decomposition:
- Package fifo_pkg holds:
  - function clog2-free DEPTH calc helper
  - typedef fifo_ptr_t parametrised via ADDR_W default
  - localparam defaults for DATA_W, ADDR_W, AF_LVL, AE_LVL
- Sub-module fifo_mem: simple dual-port array, one write port and one registered read port, no reset. fifo_buf instantiates it and owns pointers, flags and count.

Test Plan:
- Reset then idle -> emp=1, full=0, count=0, almost_empty=1, rd_valid=0.
- Write 32 words 0x00..0x1F -> almost_empty drops at count=5, almost_full rises at count=28, full=1 at count=32. A 33rd write is rejected, count stays 32, and ovf=1 with FIFO_ERR_EN.
- Read 32 words from full -> rd_data=0x00..0x1F in order, each one cycle after its read with rd_valid=1, and emp=1 after the last. An extra read is rejected, rd_valid=0, and udf=1 with FIFO_ERR_EN.
- Hold count=10 and assert rd and wr together for 20 cycles -> count stays 10 and data order is preserved. Simultaneous rd and wr at full -> count=31. At empty -> count=1.
- 100 interleaved write/read pairs -> pointers wrap past 63 to 0, and no data loss or reordering occurs.
- Assert rst mid-burst at count=17 -> count=0 and emp=1 asynchronously, before the next clock edge. The next write/read returns the new data only.
